// File: rtl/b16fp_pkg.sv
// Shared bfloat16 definitions for the MAC datapath arithmetic blocks.
// Field widths, special encodings, operand classes and divider states.
package b16fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 7;
    localparam int BIAS   = 127;

    localparam logic [15:0] QNAN    = 16'h7FC0;
    localparam logic [15:0] POS_INF = 16'h7F80;
    localparam logic [15:0] NEG_INF = 16'hFF80;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fpcls_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ROUND,
        OUT
    } div_state_e;

    // Denormals flush to zero, so a zero exponent is always zero.
    function automatic fpcls_e fp_class(
        input logic [EXP_W-1:0]  e,
        input logic [FRAC_W-1:0] f
    );
        fpcls_e c;
        if (e == '0)
            c = CLS_ZERO;
        else if (e != '1)
            c = CLS_NORM;
        else if (f == '0)
            c = CLS_INF;
        else
            c = CLS_NAN;
        return c;
    endfunction

endpackage

// File: rtl/b16fp_rne_round.sv
// Round-to-nearest-even and exponent saturation for bfloat16 results.
// Shared by the divider and the multiplier.
module b16fp_rne_round
    import b16fp_pkg::*;
(
    input  logic              sign,
    input  logic [6:0]        mant,
    input  logic              guard,
    input  logic              sticky,
    input  logic signed [9:0] exp_in,
    output logic [15:0]       result
);

    logic              inc;
    logic [7:0]        sum;
    logic signed [9:0] exp_r;

    // Round, carry a mantissa wrap into the exponent, then saturate.
    always_comb begin
        inc   = guard & (sticky | mant[0]);
        sum   = {1'b0, mant} + {7'b0, inc};
        exp_r = exp_in + $signed({9'b0, sum[7]});
        if (exp_r >= 10'sd255)
            result = sign ? NEG_INF : POS_INF;
        else if (exp_r <= 10'sd0)
            result = {sign, 15'h0};
        else
            result = {sign, exp_r[7:0], sum[6:0]};
    end

endmodule

// File: rtl/b16fpdiv.sv
// Sequential bfloat16 divider: Result = oprA / oprB.
// Restoring 10-step significand division, then one RNE round cycle.
module b16fpdiv
    import b16fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] oprA,
    input  logic [15:0] oprB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Result
);

    div_state_e state, state_nx;

    logic [9:0]        q;
    logic [8:0]        rem;
    logic [8:0]        rem_nx;
    logic [7:0]        mb;
    logic signed [9:0] ex;
    logic              sgn;
    logic [3:0]        cnt;
    logic [15:0]       res;

    fpcls_e            ca, cb;
    logic              sgn_in;
    logic              special;
    logic [15:0]       spec_res;
    logic              ge;

    logic [6:0]        rmant;
    logic              rguard, rsticky;
    logic signed [9:0] rexp;
    logic [15:0]       rres;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign Result    = res;

    // Classify the operands presented on the input and pick any special result.
    always_comb begin
        ca       = fp_class(oprA[14:7], oprA[6:0]);
        cb       = fp_class(oprB[14:7], oprB[6:0]);
        sgn_in   = oprA[15] ^ oprB[15];
        special  = 1'b1;
        spec_res = QNAN;
        if (ca == CLS_NAN || cb == CLS_NAN ||
            (ca == CLS_ZERO && cb == CLS_ZERO) ||
            (ca == CLS_INF && cb == CLS_INF))
            spec_res = QNAN;
        else if (cb == CLS_ZERO || ca == CLS_INF)
            spec_res = sgn_in ? NEG_INF : POS_INF;
        else if (ca == CLS_ZERO || cb == CLS_INF)
            spec_res = {sgn_in, 15'h0};
        else
            special = 1'b0;
    end

    // One restoring step; the remainder stays below 2*mB so 9 bits suffice.
    always_comb begin
        ge     = (rem >= {1'b0, mb});
        rem_nx = (ge ? rem - {1'b0, mb} : rem) << 1;
    end

    // Pick mantissa, guard and sticky depending on whether q >= 1.
    always_comb begin
        if (q[9]) begin
            rmant   = q[8:2];
            rguard  = q[1];
            rsticky = q[0] | (|rem);
            rexp    = ex;
        end else begin
            rmant   = q[7:1];
            rguard  = q[0];
            rsticky = |rem;
            rexp    = ex - 10'sd1;
        end
    end

    b16fp_rne_round u_round (
        .sign   (sgn),
        .mant   (rmant),
        .guard  (rguard),
        .sticky (rsticky),
        .exp_in (rexp),
        .result (rres)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (in_valid) state_nx = special ? OUT : CALC;
            CALC:  if (cnt == 4'd9) state_nx = ROUND;
            ROUND: state_nx = OUT;
            OUT:   if (out_ready) state_nx = IDLE;
        endcase
    end

    // Operand capture, division steps and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            rem <= '0;
            mb  <= '0;
            ex  <= '0;
            sgn <= 1'b0;
            cnt <= '0;
            res <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && special) begin
                        res <= spec_res;
                    end else if (in_valid) begin
                        rem <= {2'b01, oprA[6:0]};
                        mb  <= {1'b1, oprB[6:0]};
                        q   <= '0;
                        cnt <= '0;
                        sgn <= sgn_in;
                        ex  <= $signed({2'b0, oprA[14:7]})
                             - $signed({2'b0, oprB[14:7]})
                             + 10'(BIAS);
                    end
                end
                CALC: begin
                    q   <= {q[8:0], ge};
                    rem <= rem_nx;
                    cnt <= cnt + 4'd1;
                end
                ROUND: res <= rres;
                OUT: ;
            endcase
        end
    end

endmodule

// File: tb/tb_b16fpdiv.sv
// Scoreboard bench for b16fpdiv: directed vectors, random operands,
// backpressure, and reset abort.
module tb_b16fpdiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] oprA = '0;
    logic [15:0] oprB = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] Result;

    int checks = 0;
    int errors = 0;
    logic [15:0] expq[$];

    always #5 clk = ~clk;

    b16fpdiv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .oprA      (oprA),
        .oprB      (oprB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result)
    );

    // Exact-quotient reference: long integer division, then RNE.
    function automatic logic [15:0] ref_div(
        input logic [15:0] a,
        input logic [15:0] b,
        output bit sp
    );
        int ea, eb, p, sh, m8, e;
        bit s, za, zb, ia, ib, na, nb, up;
        longint num, den, nq, rm, lower, half;
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        s  = a[15] ^ b[15];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[6:0] == 0);
        ib = (eb == 255) && (b[6:0] == 0);
        na = (ea == 255) && (a[6:0] != 0);
        nb = (eb == 255) && (b[6:0] != 0);
        sp = 1'b1;
        if (na || nb || (za && zb) || (ia && ib))
            return 16'h7FC0;
        if (zb || ia)
            return s ? 16'hFF80 : 16'h7F80;
        if (za || ib)
            return {s, 15'h0};
        sp  = 1'b0;
        num = longint'(128 + int'(a[6:0])) << 16;
        den = longint'(128 + int'(b[6:0]));
        nq  = num / den;
        rm  = num % den;
        p   = (nq >= 65536) ? 16 : 15;
        sh  = p - 7;
        m8  = int'(nq >> sh);
        lower = nq & ((64'sd1 << sh) - 1);
        half  = 64'sd1 << (sh - 1);
        up = (lower > half) ||
             ((lower == half) && ((rm != 0) || (m8 % 2 == 1)));
        m8 = m8 + int'(up);
        e  = ea - eb + 127 + p - 16;
        if (m8 == 256) begin
            m8 = 128;
            e  = e + 1;
        end
        if (e >= 255)
            return s ? 16'hFF80 : 16'h7F80;
        if (e <= 0)
            return {s, 15'h0};
        return {s, 8'(e), 7'(m8)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Monitor: each output handshake retires one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result: unexpected output %h", Result);
            end else begin
                chk($sformatf("result"), {16'h0, Result},
                    {16'h0, expq.pop_front()});
            end
        end
    end

    // Issue one operation; latency is counted in edges after the accept edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] want, input bit use_want,
                          input bit drain);
        logic [15:0] e;
        bit sp, busy_ready;
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_wait: got 0 want 1");
            return;
        end
        e = ref_div(a, b, sp);
        if (use_want)
            e = want;
        expq.push_back(e);
        oprA = a;
        oprB = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        oprA = 16'($urandom);
        oprB = 16'($urandom);
        n = 0;
        busy_ready = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready)
                busy_ready = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, sp ? 0 : 11);
        chk("in_ready_busy", {31'b0, busy_ready}, 0);
        if (drain) begin
            @(posedge clk);
            #1;
            chk("in_ready_after", {31'b0, in_ready}, 1);
            chk("out_valid_after", {31'b0, out_valid}, 0);
        end
    endtask

    logic [15:0] da[14];
    logic [15:0] db[14];
    logic [15:0] dr[14];
    logic [15:0] a, b, held;
    int r;

    initial begin
        da = '{16'h4040, 16'h3F80, 16'h3F80, 16'h4000, 16'hC000,
               16'h0000, 16'h7F80, 16'h0000, 16'h7F00, 16'h0080,
               16'h8080, 16'h7FC1, 16'h7F80, 16'h4000};
        db = '{16'h4000, 16'h4040, 16'h3F80, 16'h0000, 16'h0000,
               16'h0000, 16'hFF80, 16'h4000, 16'h3E80, 16'h4700,
               16'h4700, 16'h3F80, 16'hC000, 16'hFF80};
        dr = '{16'h3FC0, 16'h3EAB, 16'h3F80, 16'h7F80, 16'hFF80,
               16'h7FC0, 16'h7FC0, 16'h0000, 16'h7F80, 16'h0000,
               16'h8000, 16'h7FC0, 16'hFF80, 16'h8000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        chk("reset_in_ready", {31'b0, in_ready}, 1);
        chk("reset_result", {16'h0, Result}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++)
            run_op(da[i], db[i], dr[i], 1'b1, 1'b1);

        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            r = int'($urandom_range(0, 9));
            case (r)
                0: a[14:7] = 8'h00;
                1: b[14:7] = 8'h00;
                2: a[14:7] = 8'hFF;
                3: b[14:7] = 8'hFF;
                4: a[14:7] = 8'($urandom_range(240, 254));
                5: a[14:7] = 8'($urandom_range(1, 12));
                default: ;
            endcase
            run_op(a, b, 16'h0, 1'b0, 1'b1);
        end

        // Backpressure: Result must hold and input pulses must be ignored.
        out_ready = 1'b0;
        run_op(16'h4040, 16'h4000, 16'h3FC0, 1'b1, 1'b0);
        held = Result;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            oprA = 16'($urandom);
            oprB = 16'($urandom);
            @(posedge clk);
            #1;
            chk("stall_out_valid", {31'b0, out_valid}, 1);
            chk("stall_result", {16'h0, Result}, {16'h0, held});
            chk("stall_in_ready", {31'b0, in_ready}, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", {31'b0, in_ready}, 1);
        run_op(16'h3F80, 16'h4040, 16'h3EAB, 1'b1, 1'b1);

        // Reset during the fifth CALC cycle aborts with no output.
        oprA = 16'h4040;
        oprB = 16'h4000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'b0, out_valid}, 0);
        chk("abort_in_ready", {31'b0, in_ready}, 1);
        chk("abort_result", {16'h0, Result}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(16'h4040, 16'h4000, 16'h3FC0, 1'b1, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
